aes_round_sched: RTL

Round scheduler for the iterative AES-128 encryption datapath. It accepts one block request at a time, then drives the datapath through three phases: the initial AddRoundKey load, NR rounds with key-schedule stepping, and a held result-valid handshake. It sits between the host-side request interface and the AES state/key registers, and it is the only block that sequences them.

---
 rtl/aes_round_sched.sv | 138 +++++++++++++
 1 files changed

// File: rtl/aes_round_sched.sv
// aes_round_sched: round scheduler for an iterative AES-128 encryption datapath.
// Accepts one block request at a time. It then sequences the initial
// AddRoundKey load and NR cipher rounds, and holds out_valid until the host
// takes the result.
// Optional feature: define AES_SCHED_BLKCNT_EN to add the completed-block
// counter (parameter CNT_W, output blk_count).
module aes_round_sched #(
    parameter int NR = 10
`ifdef AES_SCHED_BLKCNT_EN
    ,parameter int CNT_W = 16
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_valid,
    output logic       start_ready,
    input  logic       abort,
    output logic       load,
    output logic       round_en,
    output logic [3:0] round_idx,
    output logic       last_round,
    output logic       key_step,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
`ifdef AES_SCHED_BLKCNT_EN
    ,output logic [CNT_W-1:0] blk_count
`endif
);

    // state | meaning
    // IDLE  | waiting for a request, start_ready high
    // LOAD  | datapath loads plaintext XOR key, first key step
    // ROUND | one cipher round per cycle, round_idx 1..NR
    // DONE  | ciphertext valid, held until out_ready or abort
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_ROUND = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [3:0] LAST_IDX = NR[3:0];

    logic [1:0] state_q, state_d;
    logic [3:0] round_q, round_d;

    // Next-state and round counter; round_q is kept at 0 outside ROUND so it
    // can drive round_idx directly.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        case (state_q)
            S_IDLE: begin
                round_d = 4'd0;
                if (start_valid) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    state_d = S_IDLE;
                    round_d = 4'd0;
                end else begin
                    state_d = S_ROUND;
                    round_d = 4'd1;
                end
            end
            S_ROUND: begin
                if (abort) begin
                    state_d = S_IDLE;
                    round_d = 4'd0;
                end else if (round_q == LAST_IDX) begin
                    state_d = S_DONE;
                    round_d = 4'd0;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            S_DONE: begin
                round_d = 4'd0;
                if (abort || out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                round_d = 4'd0;
            end
        endcase
    end

    // State and round counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            round_q <= 4'd0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
        end
    end

    // Outputs decoded only from registered state, never from inputs.
    always_comb begin
        start_ready = (state_q == S_IDLE);
        busy        = (state_q != S_IDLE);
        load        = (state_q == S_LOAD);
        round_en    = (state_q == S_ROUND);
        round_idx   = round_q;
        last_round  = (state_q == S_ROUND) && (round_q == LAST_IDX);
        key_step    = (state_q == S_LOAD) ||
                      ((state_q == S_ROUND) && (round_q < LAST_IDX));
        out_valid   = (state_q == S_DONE);
    end

`ifdef AES_SCHED_BLKCNT_EN
    logic [CNT_W-1:0] blk_count_q, blk_count_d;

    // A block counts only when its result is handed over without an abort.
    always_comb begin
        blk_count_d = blk_count_q;
        if ((state_q == S_DONE) && out_ready && !abort) begin
            blk_count_d = blk_count_q + 1'b1;
        end
    end

    // Completed-block counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_count_q <= '0;
        end else begin
            blk_count_q <= blk_count_d;
        end
    end

    assign blk_count = blk_count_q;
`endif

endmodule
